// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Steps the 8-bit programmable counter through a table of count segments.
//   Each segment loads the counter with its start value, then enables it in
//   the segment's direction until the counter reaches the segment's end value.
//   Once the last segment finishes, the program either restarts at segment 0
//   or ends and pulses done.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_we/addr/start/end/up
//                         segment table write, accepted only while idle
//   cfg_last, loop_en     program length and loop mode, read live at each
//                         segment boundary
//   go, stop              start / abort pulses (stop has priority)
//   cnt_value             counter output fed back from the datapath
//   cnt_load/_val/en/up   counter control strobes
//   busy, seg_idx, done   program status; done pulses in the final boundary cycle
//   err                   sticky flag: table write attempted while busy
module counter_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_start,
  input  logic [WIDTH-1:0] cfg_end,
  input  logic             cfg_up,
  input  logic [AW-1:0]    cfg_last,
  input  logic             loop_en,
  input  logic             go,
  input  logic             stop,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             cnt_en,
  output logic             cnt_up,
  output logic             busy,
  output logic [AW-1:0]    seg_idx,
  output logic             done,
  output logic             err
);

  typedef struct packed {
    logic [WIDTH-1:0] start_v;
    logic [WIDTH-1:0] end_v;
    logic             up;
  } seg_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_NEXT} state_t;

  seg_t          tbl [DEPTH];
  state_t        state, state_nx;
  logic [AW-1:0] seg_nx;
  logic [AW-1:0] seg_inc;
  seg_t          cur;
  logic          at_end;
  logic          go_ok;

  assign cur    = tbl[seg_idx];
  assign at_end = (cnt_value == cur.end_v);
  assign busy   = (state != S_IDLE);
  assign go_ok  = go && !stop && (state == S_IDLE);

  // Increment wraps at DEPTH so a lowered cfg_last is eventually met again.
  assign seg_inc = (seg_idx == AW'(DEPTH - 1)) ? '0 : seg_idx + 1'b1;

  always_comb begin
    state_nx     = state;
    seg_nx       = seg_idx;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    cnt_up       = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          state_nx = S_LOAD;
          seg_nx   = '0;
        end
      end
      S_LOAD: begin
        cnt_load     = 1'b1;
        cnt_load_val = cur.start_v;
        cnt_up       = cur.up;
        state_nx     = S_RUN;
      end
      S_RUN: begin
        cnt_up = cur.up;
        cnt_en = !at_end;
        if (at_end) state_nx = S_NEXT;
      end
      S_NEXT: begin
        if (seg_idx != cfg_last) begin
          seg_nx   = seg_inc;
          state_nx = S_LOAD;
        end else if (loop_en) begin
          seg_nx   = '0;
          state_nx = S_LOAD;
        end else begin
          done     = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    // Abort overrides everything: strobes drop in this same cycle so the
    // counter never takes another step or load.
    if (stop) begin
      state_nx = S_IDLE;
      seg_nx   = seg_idx;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      done     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      seg_idx <= '0;
      err     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else begin
      state   <= state_nx;
      seg_idx <= seg_nx;
      if (cfg_we && busy) err <= 1'b1;
      else if (go_ok)     err <= 1'b0;
      if (cfg_we && !busy) tbl[cfg_addr] <= '{start_v: cfg_start, end_v: cfg_end, up: cfg_up};
    end
  end

endmodule
